// File: rtl/store_buffered_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : store_buffered_data_memory
// Purpose  : Data-memory stage behind the single-cycle datapath. Stores are
//            queued in a FIFO write buffer and retired to a word RAM at one
//            entry per cycle. Loads are answered combinationally, with
//            store-to-load forwarding from the youngest matching entry.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous, active-high reset
//            MemWrite   - store request this cycle
//            MemRead    - load request this cycle
//            Addr       - byte address; word index = Addr[addr_bits+1:2]
//            WriteData  - store data
//            RD_Data    - load data (combinational)
//            stall      - store refused this cycle (buffer full)
//            buf_count  - number of valid buffer entries
//            buf_empty  - buffer holds no entries
// Revision : 1.0  initial release
// ============================================================================
module store_buffered_data_memory #(
  parameter int datasize  = 32,
  parameter int depth     = 4,
  parameter int addr_bits = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemWrite,
  input  logic                    MemRead,
  input  logic [datasize-1:0]     Addr,
  input  logic [datasize-1:0]     WriteData,
  output logic [datasize-1:0]     RD_Data,
  output logic                    stall,
  output logic [$clog2(depth):0]  buf_count,
  output logic                    buf_empty
);

  localparam int PW    = $clog2(depth);
  localparam int CW    = PW + 1;
  localparam int WORDS = 1 << addr_bits;
  localparam logic [CW-1:0] c_full = CW'(depth);

  // Word RAM and write-buffer storage
  logic [datasize-1:0]  r_ram [WORDS];
  logic [addr_bits-1:0] r_idx [depth];
  logic [datasize-1:0]  r_dat [depth];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;

  logic [addr_bits-1:0] w_widx;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_ram_busy;
  logic                 w_fwd_hit;
  logic [datasize-1:0]  w_fwd_data;
  logic [PW-1:0]        w_pos;
  logic                 w_addr_unused;

  // Byte-offset bits and bits above the word index are ignored (aliasing).
  assign w_widx        = Addr[addr_bits+1:2];
  assign w_addr_unused = ^{Addr[1:0], Addr[datasize-1:addr_bits+2]};

  // Retire hold: tied low in the datapath. Holding retirement is the only
  // way the buffer can accumulate more than one entry, so it is kept as an
  // explicit net that can be overridden to exercise back-pressure.
  assign w_ram_busy = 1'b0;

  assign w_full    = (r_count == c_full);
  assign stall     = MemWrite & w_full;
  assign w_push    = MemWrite & ~w_full;
  assign w_pop     = (r_count != '0) & ~w_ram_busy;
  assign buf_count = r_count;
  assign buf_empty = (r_count == '0);

  // Pointer and occupancy bookkeeping. Pointers wrap naturally at depth
  // because depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Buffer payload needs no reset: validity is defined by head/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_idx[r_tail] <= w_widx;
      r_dat[r_tail] <= WriteData;
    end
  end

  // Word RAM; reset clears every word and discards pending stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) r_ram[i] <= '0;
    end else if (w_pop) begin
      r_ram[r_idx[r_head]] <= r_dat[r_head];
    end
  end

  // Forwarding search, walked oldest to youngest so the last hit wins.
  // The head entry retiring this cycle is still valid here.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_pos      = '0;
    for (int i = 0; i < depth; i++) begin
      w_pos = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_idx[w_pos] == w_widx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_dat[w_pos];
      end
    end
  end

  // A same-cycle store is not yet in the buffer, so the load sees the
  // contents before it.
  assign RD_Data = (MemRead && w_fwd_hit) ? w_fwd_data : r_ram[w_widx];

endmodule
`default_nettype wire

// File: tb/tb_store_buffered_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffered_data_memory
// Purpose  : Directed bench for store_buffered_data_memory with a queue-based
//            reference model and per-cycle output comparison.
// Revision : 1.0  initial release
// ============================================================================
module tb_store_buffered_data_memory;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] RD_Data;
  logic        stall;
  logic [2:0]  buf_count;
  logic        buf_empty;

  store_buffered_data_memory #(.datasize(32), .depth(DEPTH), .addr_bits(6)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Addr(Addr), .WriteData(WriteData), .RD_Data(RD_Data), .stall(stall),
    .buf_count(buf_count), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO queue of pending stores plus a plain word array.
  typedef struct { logic [5:0] idx; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic [31:0] mem [64];
  bit          busy_m = 1'b0;

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  function automatic logic [31:0] model_rd();
    logic [5:0]  idx;
    logic [31:0] r;
    idx = Addr[7:2];
    r   = mem[idx];
    if (MemRead)
      foreach (q[i]) if (q[i].idx == idx) r = q[i].d;
    return r;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      bit full;
      ent_t e;
      full = (q.size() == DEPTH);
      if (q.size() > 0 && !busy_m) begin
        mem[q[0].idx] = q[0].d;
        void'(q.pop_front());
      end
      if (MemWrite && !full) begin
        e.idx = Addr[7:2];
        e.d   = WriteData;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    check("rd_data", RD_Data, model_rd());
    check("buf_count", {29'd0, buf_count}, q.size());
    check("buf_empty", {31'd0, buf_empty}, {31'd0, q.size() == 0});
    check("stall", {31'd0, stall}, {31'd0, MemWrite && (q.size() == DEPTH)});
    check("count_bound", {31'd0, buf_count > 3'(DEPTH)}, 32'd0);
  end

  task automatic drive(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    MemWrite  = w;
    MemRead   = r;
    Addr      = a;
    WriteData = d;
    @(negedge clk);
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    drive(0, 1, 32'h10, 0);
    check("rst_rd", RD_Data, 32'h0);
    check("rst_count", {29'd0, buf_count}, 32'd0);
    check("rst_empty", {31'd0, buf_empty}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);

    // Single store, forwarded then retired
    drive(1, 0, 32'h20, 32'hDEADBEEF);
    drive(0, 1, 32'h20, 0);
    check("fwd_rd", RD_Data, 32'hDEADBEEF);
    check("fwd_count", {29'd0, buf_count}, 32'd1);
    drive(0, 1, 32'h20, 0);
    check("ret_count", {29'd0, buf_count}, 32'd0);
    check("ret_rd", RD_Data, 32'hDEADBEEF);

    // Back-to-back stores to one word, load with the third
    drive(1, 0, 32'h40, 32'h1);
    drive(1, 0, 32'h40, 32'h2);
    drive(1, 1, 32'h40, 32'h3);
    check("same_cyc_rd", RD_Data, 32'h2);
    drive(0, 1, 32'h40, 0);
    check("next_rd", RD_Data, 32'h3);
    drive(0, 0, 0, 0);
    drive(0, 1, 32'h141, 0);
    check("alias_rd", RD_Data, 32'h3);

    // Fill to stall with retirement held
    force dut.w_ram_busy = 1'b1;
    busy_m = 1'b1;
    for (int k = 0; k < 4; k++) drive(1, 0, 32'h80 + 4 * k, 32'hA0 + k);
    drive(1, 0, 32'h90, 32'hA4);
    check("full_stall", {31'd0, stall}, 32'd1);
    check("full_count", {29'd0, buf_count}, 32'd4);
    release dut.w_ram_busy;
    busy_m = 1'b0;
    drive(1, 0, 32'h90, 32'hA4);
    check("held_stall", {31'd0, stall}, 32'd0);
    check("held_count", {29'd0, buf_count}, 32'd3);
    repeat (6) drive(0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 32'h80 + 4 * k, 0);
      check("stall_ram", RD_Data, 32'hA0 + k);
    end

    // Pointer wrap: 3*depth distinct stores
    for (int k = 0; k < 3 * DEPTH; k++) drive(1, 0, 4 * k, 32'h100 + k);
    repeat (3) drive(0, 0, 0, 0);
    for (int k = 0; k < 3 * DEPTH; k++) begin
      drive(0, 1, 4 * k, 0);
      check("wrap_ram", RD_Data, 32'h100 + k);
    end

    // Asynchronous reset with two pending stores
    force dut.w_ram_busy = 1'b1;
    busy_m = 1'b1;
    drive(1, 0, 32'hC0, 32'h55);
    drive(1, 0, 32'hC4, 32'h66);
    drive(0, 0, 32'hC0, 0);
    check("pre_rst_count", {29'd0, buf_count}, 32'd2);
    #2 reset = 1'b1;
    model_clear();
    #1;
    check("async_count", {29'd0, buf_count}, 32'd0);
    check("async_empty", {31'd0, buf_empty}, 32'd1);
    check("async_rd", RD_Data, 32'h0);
    release dut.w_ram_busy;
    busy_m = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    drive(0, 1, 32'hC0, 0);
    check("disc_rd0", RD_Data, 32'h0);
    drive(0, 1, 32'hC4, 0);
    check("disc_rd1", RD_Data, 32'h0);
    drive(0, 1, 32'h20, 0);
    check("rst_ram_clr", RD_Data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
